// File: rtl/rect_overlay_gen.sv
// rect_overlay_gen: draws NUM_RECTS programmable rectangles through a
// writable palette. Rectangle edits go to a shadow set and are committed
// to the active set on each v_sync rising edge. Three-stage pixel pipeline;
// sync and draw_area are delayed to line up with the RGB output.
module rect_overlay_gen #(
  parameter int NUM_RECTS   = 8,
  parameter int COORD_W     = 12,
  parameter int PAL_BITS    = 4,
  parameter int BLINK_DIV_W = 5,
  localparam int ADDR_W     = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1,
  localparam int CFG_W      = 4 * COORD_W + 2 * PAL_BITS + 2
) (
  input  logic               pixclk,
  input  logic               reset,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               h_sync,
  input  logic               v_sync,
  input  logic               draw_area,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [CFG_W-1:0]   cfg_data,
  input  logic               pal_we,
  input  logic [PAL_BITS-1:0] pal_addr,
  input  logic [23:0]        pal_data,
  output logic [7:0]         red,
  output logic [7:0]         green,
  output logic [7:0]         blue,
  output logic               h_sync_o,
  output logic               v_sync_o,
  output logic               draw_area_o,
  output logic               blink_phase
);

  localparam int PAL_DEPTH = 2 ** PAL_BITS;

  logic                   vs_prev_reg;
  logic [BLINK_DIV_W-1:0] frame_cnt_reg;
  logic                   frame_edge;
  logic [NUM_RECTS-1:0]   hit_vec;
  logic [PAL_BITS-1:0]    idx_vec [NUM_RECTS];
  logic [PAL_BITS-1:0]    idx_s2_reg;
  logic [PAL_BITS-1:0]    idx_s2_next;
  logic [23:0]            rgb_s3_reg;
  logic [23:0]            pal_reg [PAL_DEPTH];
  logic [2:0]             hs_dly_reg;
  logic [2:0]             vs_dly_reg;
  logic [2:0]             da_dly_reg;

  // A frame starts on the first cycle v_sync is seen high
  assign frame_edge  = v_sync & ~vs_prev_reg;
  assign blink_phase = frame_cnt_reg[BLINK_DIV_W-1];

  // Edge detector and frame counter that drives the blink phase
  always_ff @(posedge pixclk) begin
    if (reset) begin
      vs_prev_reg   <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      vs_prev_reg <= v_sync;
      if (frame_edge) begin
        frame_cnt_reg <= frame_cnt_reg + BLINK_DIV_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RECTS; gi++) begin : g_rect
    logic [CFG_W-1:0]    shadow_reg;
    logic [CFG_W-1:0]    active_reg;
    logic                hit_s1_reg;
    logic [PAL_BITS-1:0] idx_s1_reg;
    logic                en;
    logic                blink;
    logic [PAL_BITS-1:0] on_idx;
    logic [PAL_BITS-1:0] off_idx;
    logic [COORD_W-1:0]  x0;
    logic [COORD_W-1:0]  x1;
    logic [COORD_W-1:0]  y0;
    logic [COORD_W-1:0]  y1;
    logic                hit_now;

    assign {en, blink, on_idx, off_idx, x0, x1, y0, y1} = active_reg;
    // Inclusive unsigned bounds; an inverted range simply never matches
    assign hit_now = en && (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);

    // Shadow takes CPU writes; active copies the old shadow at frame start,
    // so a write landing on the boundary cycle waits for the next frame
    always_ff @(posedge pixclk) begin
      if (reset) begin
        shadow_reg <= '0;
        active_reg <= '0;
      end else begin
        if (frame_edge) begin
          active_reg <= shadow_reg;
        end
        if (cfg_we && (cfg_addr == ADDR_W'(gi))) begin
          shadow_reg <= cfg_data;
        end
      end
    end

    // S1: per-rectangle hit flag and blink-selected palette index
    always_ff @(posedge pixclk) begin
      if (reset) begin
        hit_s1_reg <= 1'b0;
        idx_s1_reg <= '0;
      end else begin
        hit_s1_reg <= hit_now;
        idx_s1_reg <= (blink && blink_phase) ? off_idx : on_idx;
      end
    end

    assign hit_vec[gi] = hit_s1_reg;
    assign idx_vec[gi] = idx_s1_reg;
  end

  // Lowest-index hit wins; background index 0 when nothing hits
  always_comb begin
    idx_s2_next = '0;
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        idx_s2_next = idx_vec[i];
      end
    end
  end

  // S2: register the winning palette index
  always_ff @(posedge pixclk) begin
    if (reset) begin
      idx_s2_reg <= '0;
    end else begin
      idx_s2_reg <= idx_s2_next;
    end
  end

  function automatic logic [23:0] pal_init(input int i);
    case (i)
      0:       return 24'h000000;
      1:       return 24'hDB203E;
      2:       return 24'h4D191B;
      3:       return 24'hA8B043;
      4:       return 24'h2B3314;
      5:       return 24'hFFA900;
      6:       return 24'h472812;
      7:       return 24'hFFFFFF;
      default: return 24'h7F7F7F;
    endcase
  endfunction

  // Palette storage; reload defaults on reset, otherwise take writes
  always_ff @(posedge pixclk) begin
    if (reset) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        pal_reg[i] <= pal_init(i);
      end
    end else if (pal_we) begin
      pal_reg[pal_addr] <= pal_data;
    end
  end

  // S3: palette lookup (sees pre-write contents) gated by aligned draw_area
  always_ff @(posedge pixclk) begin
    if (reset) begin
      rgb_s3_reg <= '0;
    end else begin
      rgb_s3_reg <= da_dly_reg[1] ? pal_reg[idx_s2_reg] : 24'h000000;
    end
  end

  // Three-stage delay of the timing signals to match the pixel pipeline
  always_ff @(posedge pixclk) begin
    if (reset) begin
      hs_dly_reg <= '0;
      vs_dly_reg <= '0;
      da_dly_reg <= '0;
    end else begin
      hs_dly_reg <= {hs_dly_reg[1:0], h_sync};
      vs_dly_reg <= {vs_dly_reg[1:0], v_sync};
      da_dly_reg <= {da_dly_reg[1:0], draw_area};
    end
  end

  assign {red, green, blue} = rgb_s3_reg;
  assign h_sync_o           = hs_dly_reg[2];
  assign v_sync_o           = vs_dly_reg[2];
  assign draw_area_o        = da_dly_reg[2];

endmodule

// File: tb/tb_rect_overlay_gen.sv
// Testbench for rect_overlay_gen: directed scenarios with literal colours
// and a randomized stream checked against a frame-level reference model.
module tb_rect_overlay_gen;

  logic        pixclk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] x = '0;
  logic [11:0] y = '0;
  logic        h_sync = 1'b0;
  logic        v_sync = 1'b0;
  logic        draw_area = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [57:0] cfg_data = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = '0;
  logic [23:0] pal_data = '0;
  logic [7:0]  red, green, blue;
  logic        h_sync_o, v_sync_o, draw_area_o, blink_phase;

  int n_pass = 0;
  int n_tot  = 0;

  rect_overlay_gen dut (
    .pixclk(pixclk), .reset(reset), .x(x), .y(y),
    .h_sync(h_sync), .v_sync(v_sync), .draw_area(draw_area),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .red(red), .green(green), .blue(blue),
    .h_sync_o(h_sync_o), .v_sync_o(v_sync_o), .draw_area_o(draw_area_o),
    .blink_phase(blink_phase)
  );

  always #5 pixclk = ~pixclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] idx;
    logic       da;
    logic       hs;
    logic       vs;
  } pix_t;

  logic [57:0] sh_m  [8];
  logic [57:0] act_m [8];
  logic [23:0] pal_m [16];
  int          frame_m;
  logic        vsp_m;
  pix_t        pq[$];
  logic [23:0] exp_rgb;
  logic [3:0]  exp_tim;  // {h_sync_o, v_sync_o, draw_area_o, blink_phase}

  function automatic logic [57:0] mk(input logic en, input logic bl,
                                     input logic [3:0] on, input logic [3:0] off,
                                     input logic [11:0] x0, input logic [11:0] x1,
                                     input logic [11:0] y0, input logic [11:0] y1);
    return {en, bl, on, off, x0, x1, y0, y1};
  endfunction

  function automatic logic [23:0] default_colour(input int i);
    logic [23:0] tbl [8];
    tbl = '{24'h000000, 24'hDB203E, 24'h4D191B, 24'hA8B043,
            24'h2B3314, 24'hFFA900, 24'h472812, 24'hFFFFFF};
    return (i < 8) ? tbl[i] : 24'h7F7F7F;
  endfunction

  // First enabled rectangle containing the pixel decides the colour index
  function automatic logic [3:0] model_index(input logic [11:0] px, input logic [11:0] py);
    logic [57:0] r;
    for (int i = 0; i < 8; i++) begin
      r = act_m[i];
      if (r[57] && px >= r[47:36] && px <= r[35:24] && py >= r[23:12] && py <= r[11:0])
        return (r[56] && frame_m >= 16) ? r[51:48] : r[55:52];
    end
    return 4'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      sh_m[i]  = '0;
      act_m[i] = '0;
    end
    for (int i = 0; i < 16; i++) pal_m[i] = default_colour(i);
    frame_m = 0;
    vsp_m   = 1'b0;
    pq.delete();
    pq.push_back('0);
    pq.push_back('0);
  endtask

  // One pixel clock: drive inputs, advance model, wait for the edge.
  // Afterwards exp_rgb/exp_tim hold what the outputs must show.
  task automatic tick(input logic [11:0] xi, input logic [11:0] yi,
                      input logic hi, input logic vi, input logic di);
    pix_t p;
    pix_t q;
    x = xi; y = yi; h_sync = hi; v_sync = vi; draw_area = di;
    if (reset) begin
      model_reset();
      exp_rgb = '0;
      exp_tim = '0;
    end else begin
      p.idx = model_index(xi, yi);
      p.da = di; p.hs = hi; p.vs = vi;
      pq.push_back(p);
      q = pq.pop_front();
      exp_rgb = q.da ? pal_m[q.idx] : 24'h000000;
      if (vi && !vsp_m) begin
        act_m   = sh_m;
        frame_m = (frame_m + 1) % 32;
      end
      vsp_m = vi;
      if (cfg_we) sh_m[cfg_addr] = cfg_data;
      if (pal_we) pal_m[pal_addr] = pal_data;
      exp_tim = {q.hs, q.vs, q.da, (frame_m >= 16) ? 1'b1 : 1'b0};
    end
    @(posedge pixclk);
    #1;
    cfg_we = 1'b0;
    pal_we = 1'b0;
  endtask

  // Hold one pixel long enough for it to reach the output
  task automatic show(input logic [11:0] px, input logic [11:0] py, input logic da,
                      output logic [23:0] rgb);
    repeat (3) tick(px, py, 1'b0, 1'b0, da);
    rgb = {red, green, blue};
  endtask

  task automatic vs_rise();
    tick(12'd0, 12'd0, 1'b0, 1'b1, 1'b0);
    tick(12'd0, 12'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_rect(input logic [2:0] a, input logic [57:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick(12'd0, 12'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [23:0] got;
    reset = 1'b1;
    tick(12'd100, 12'd100, 1'b1, 1'b1, 1'b1);
    tick(12'd100, 12'd100, 1'b1, 1'b1, 1'b1);
    got = {red, green, blue};
    n_tot++;
    if (got !== 24'h0) $display("FAIL reset_rgb: got %h want %h", got, 24'h0);
    else n_pass++;
    n_tot++;
    if ({h_sync_o, v_sync_o, draw_area_o, blink_phase} !== 4'b0000)
      $display("FAIL reset_timing: got %b want %b",
               {h_sync_o, v_sync_o, draw_area_o, blink_phase}, 4'b0000);
    else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
           1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      got = {red, green, blue};
      n_tot++;
      if (got !== exp_rgb) $display("FAIL post_reset_rgb %0d: got %h want %h", i, got, exp_rgb);
      else n_pass++;
      n_tot++;
      if ({h_sync_o, v_sync_o, draw_area_o, blink_phase} !== exp_tim)
        $display("FAIL post_reset_delay %0d: got %b want %b", i,
                 {h_sync_o, v_sync_o, draw_area_o, blink_phase}, exp_tim);
      else n_pass++;
    end
    $display("test_reset done");
  endtask

  task automatic test_rect_commit();
    logic [23:0] got;
    logic [11:0] pts [5][2];
    logic [23:0] want [5];
    write_rect(3'd0, mk(1'b1, 1'b0, 4'd3, 4'd0, 12'd508, 12'd526, 12'd316, 12'd385));
    show(12'd508, 12'd316, 1'b1, got);
    n_tot++;
    if (got !== 24'h0) $display("FAIL rect0_before_commit: got %h want %h", got, 24'h0);
    else n_pass++;
    vs_rise();
    pts  = '{'{12'd508, 12'd316}, '{12'd526, 12'd385}, '{12'd507, 12'd316},
             '{12'd527, 12'd385}, '{12'd508, 12'd315}};
    want = '{24'hA8B043, 24'hA8B043, 24'h000000, 24'h000000, 24'h000000};
    for (int i = 0; i < 5; i++) begin
      show(pts[i][0], pts[i][1], 1'b1, got);
      n_tot++;
      if (got !== want[i])
        $display("FAIL rect0_edge (%0d,%0d): got %h want %h", pts[i][0], pts[i][1], got, want[i]);
      else begin
        n_pass++;
        $display("rect0_edge (%0d,%0d) = %h", pts[i][0], pts[i][1], got);
      end
    end
  endtask

  task automatic test_priority();
    logic [23:0] got;
    write_rect(3'd1, mk(1'b1, 1'b0, 4'd5, 4'd0, 12'd500, 12'd520, 12'd300, 12'd400));
    vs_rise();
    show(12'd510, 12'd350, 1'b1, got);
    n_tot++;
    if (got !== 24'hA8B043) $display("FAIL priority_overlap: got %h want %h", got, 24'hA8B043);
    else n_pass++;
    show(12'd502, 12'd350, 1'b1, got);
    n_tot++;
    if (got !== 24'hFFA900) $display("FAIL priority_rect1: got %h want %h", got, 24'hFFA900);
    else n_pass++;
    $display("test_priority done");
  endtask

  task automatic test_blink();
    logic [23:0] got;
    reset = 1'b1;
    tick(12'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    write_rect(3'd0, mk(1'b1, 1'b1, 4'd3, 4'd4, 12'd508, 12'd526, 12'd316, 12'd385));
    write_rect(3'd1, mk(1'b1, 1'b0, 4'd5, 4'd0, 12'd500, 12'd520, 12'd300, 12'd400));
    repeat (15) vs_rise();
    show(12'd510, 12'd350, 1'b1, got);
    n_tot++;
    if (got !== 24'hA8B043) $display("FAIL blink_15_rises: got %h want %h", got, 24'hA8B043);
    else n_pass++;
    vs_rise();
    show(12'd510, 12'd350, 1'b1, got);
    n_tot++;
    if (got !== 24'h2B3314) $display("FAIL blink_16_rises: got %h want %h", got, 24'h2B3314);
    else n_pass++;
    n_tot++;
    if (blink_phase !== 1'b1) $display("FAIL blink_phase_16: got %b want %b", blink_phase, 1'b1);
    else n_pass++;
    repeat (16) vs_rise();
    show(12'd510, 12'd350, 1'b1, got);
    n_tot++;
    if (got !== 24'hA8B043) $display("FAIL blink_32_rises: got %h want %h", got, 24'hA8B043);
    else n_pass++;
    n_tot++;
    if (blink_phase !== 1'b0) $display("FAIL blink_phase_32: got %b want %b", blink_phase, 1'b0);
    else n_pass++;
    $display("test_blink done");
  endtask

  task automatic test_palette_write();
    logic [23:0] got;
    repeat (3) tick(12'd510, 12'd350, 1'b0, 1'b0, 1'b1);
    pal_we = 1'b1; pal_addr = 4'd3; pal_data = 24'h123456;
    tick(12'd510, 12'd350, 1'b0, 1'b0, 1'b1);
    got = {red, green, blue};
    n_tot++;
    if (got !== 24'hA8B043) $display("FAIL pal_same_cycle: got %h want %h", got, 24'hA8B043);
    else n_pass++;
    tick(12'd510, 12'd350, 1'b0, 1'b0, 1'b1);
    got = {red, green, blue};
    n_tot++;
    if (got !== 24'h123456) $display("FAIL pal_next_cycle: got %h want %h", got, 24'h123456);
    else n_pass++;
    show(12'd510, 12'd350, 1'b0, got);
    n_tot++;
    if (got !== 24'h0) $display("FAIL draw_area_gate: got %h want %h", got, 24'h0);
    else n_pass++;
    $display("test_palette_write done");
  endtask

  task automatic test_boundary_write_and_reset();
    logic [23:0] got;
    cfg_we = 1'b1; cfg_addr = 3'd0;
    cfg_data = mk(1'b0, 1'b0, 4'd0, 4'd0, 12'd0, 12'd0, 12'd0, 12'd0);
    vs_rise();
    show(12'd510, 12'd350, 1'b1, got);
    n_tot++;
    if (got !== 24'h123456) $display("FAIL disable_same_frame: got %h want %h", got, 24'h123456);
    else n_pass++;
    vs_rise();
    show(12'd510, 12'd350, 1'b1, got);
    n_tot++;
    if (got !== 24'hFFA900) $display("FAIL disable_next_frame: got %h want %h", got, 24'hFFA900);
    else n_pass++;
    repeat (2) tick(12'd510, 12'd350, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    tick(12'd510, 12'd350, 1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    got = {red, green, blue};
    n_tot++;
    if (got !== 24'h0) $display("FAIL midframe_reset_rgb: got %h want %h", got, 24'h0);
    else n_pass++;
    write_rect(3'd0, mk(1'b1, 1'b0, 4'd3, 4'd0, 12'd508, 12'd526, 12'd316, 12'd385));
    show(12'd510, 12'd350, 1'b1, got);
    n_tot++;
    if (got !== 24'h0) $display("FAIL after_reset_uncommitted: got %h want %h", got, 24'h0);
    else n_pass++;
    vs_rise();
    show(12'd510, 12'd350, 1'b1, got);
    n_tot++;
    if (got !== 24'hA8B043) $display("FAIL after_reset_committed: got %h want %h", got, 24'hA8B043);
    else n_pass++;
    $display("test_boundary_write_and_reset done");
  endtask

  // Back-to-back random pixels, edits, palette writes and frame edges
  task automatic test_random_stream();
    logic [23:0] got;
    logic        vs = 1'b0;
    int          errs = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_we   = 1'b1;
        cfg_addr = 3'($urandom_range(0, 7));
        cfg_data = mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      12'($urandom_range(0, 63)), 12'($urandom_range(0, 63)),
                      12'($urandom_range(0, 63)), 12'($urandom_range(0, 63)));
      end
      if ($urandom_range(0, 15) == 0) begin
        pal_we   = 1'b1;
        pal_addr = 4'($urandom_range(0, 15));
        pal_data = 24'($urandom);
      end
      if ($urandom_range(0, 3) == 0) vs = ~vs;
      reset = ($urandom_range(0, 599) == 0);
      tick(12'($urandom_range(0, 63)), 12'($urandom_range(0, 63)),
           1'($urandom_range(0, 1)), vs, 1'($urandom_range(0, 3) != 0));
      reset = 1'b0;
      got = {red, green, blue};
      n_tot++;
      if (got !== exp_rgb) begin
        errs++;
        $display("FAIL rnd_rgb cycle %0d: got %h want %h", c, got, exp_rgb);
      end else n_pass++;
      n_tot++;
      if ({h_sync_o, v_sync_o, draw_area_o, blink_phase} !== exp_tim) begin
        errs++;
        $display("FAIL rnd_timing cycle %0d: got %b want %b", c,
                 {h_sync_o, v_sync_o, draw_area_o, blink_phase}, exp_tim);
      end else n_pass++;
    end
    $display("test_random_stream done, %0d bad cycles", errs);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rect_commit();
    test_priority();
    test_blink();
    test_palette_write();
    test_boundary_write_and_reset();
    test_random_stream();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/rect_overlay_gen.md
# rect_overlay_gen

Parametrised pixel colour generator: it replaces hard-coded bar drawing with NUM_RECTS runtime-programmable rectangles, each mapped through a writable palette. Per-rectangle blink alternates on/off colours, and rectangle changes are committed only at frame boundaries. It sits between the HvSync counters and CreateHDMIOutputs, delivering RGB plus sync/DrawArea delayed to match its pipeline.

## Interface
Parameters:
- NUM_RECTS, 8: number of rectangles; index 0 has highest priority.
- COORD_W, 12: width of x/y and rectangle bounds.
- PAL_BITS, 4: palette index width (2^PAL_BITS entries, 24-bit RGB each).
- BLINK_DIV_W, 5: blink phase = frame counter bit BLINK_DIV_W-1, so it toggles every 2^(BLINK_DIV_W-1) frames.

Ports:
- pixclk  in  1  pixel clock; single clock domain; every register is clocked on its rising edge.
- reset  in  1  synchronous, active-high reset.
- x, y  in  COORD_W each  current pixel coordinate.
- h_sync, v_sync, draw_area  in  1 each  timing from HvSync; v_sync is active-high.
- cfg_we  in  1  rectangle shadow write strobe, always accepted.
- cfg_addr  in  clog2(NUM_RECTS)  rectangle index.
- cfg_data  in  4*COORD_W+2*PAL_BITS+2  fields, MSB to LSB: enable, blink, on_idx, off_idx, x0, x1, y0, y1.
- pal_we  in  1  palette write strobe.
- pal_addr  in  PAL_BITS  palette entry.
- pal_data  in  24  {R,G,B}.
- red, green, blue  out  8 each  pixel colour.
- h_sync_o, v_sync_o, draw_area_o  out  1 each  inputs delayed to align with RGB.
- blink_phase  out  1  current blink phase.

## Operation
- Two rectangle register sets, shadow and active. cfg_we writes shadow[cfg_addr]. Out-of-range cfg_addr is ignored.
- Frame boundary is a v_sync rising edge, detected against the registered previous v_sync. On that cycle:
  - active is loaded from shadow.
  - frame_cnt (BLINK_DIV_W bits, wrapping) increments.
- cfg_we in the same cycle as a frame boundary updates shadow only. The write becomes visible at the next boundary.
- Hit test for rect i: enable && x0<=x<=x1 && y0<=y<=y1, all comparisons unsigned and inclusive. If x0>x1 or y0>y1 the rectangle never hits; there is no wrap.
- Priority: the lowest-index hitting rectangle wins. With no hit, the palette index is 0 (background).
- Index select: blink=1 and blink_phase=1 selects off_idx; otherwise on_idx.
- Palette: pal_we writes the entry in its cycle. A read in the same cycle returns the old contents.
- Output: if the aligned draw_area is 0, RGB is 0; otherwise RGB = palette[index].
- Palette reset values:
  - 0 = 000000
  - 1 = DB203E
  - 2 = 4D191B
  - 3 = A8B043
  - 4 = 2B3314
  - 5 = FFA900
  - 6 = 472812
  - 7 = FFFFFF
  - all others = 7F7F7F
- Reset:
  - all shadow and active rectangles cleared (enable=0);
  - frame_cnt=0, blink_phase=0;
  - palette loaded with the reset values;
  - every pipeline register and output is 0.
- Reset mid-frame: outputs read 0 from the first edge after reset is sampled. The first v_sync rising edge after release commits the (cleared or newly written) shadow set.

## Timing
- Latency is 3 pixclk cycles from x/y/draw_area/syncs to RGB and the *_o outputs:
  - S1 registers per-rect hit bits and selected indices.
  - S2 priority-encodes to one palette index and registers it.
  - S3 performs the palette read and draw_area gating into red/green/blue.
- Sync and draw_area pass through a 3-stage delay with no other modification.
- Active set and blink_phase change on the cycle after the boundary edge. S1 samples the new values from the next pixel onward.
- A palette write at cycle t affects S3 reads at t+1 and later.
- Sustained throughput: one pixel per cycle, no stalls.

## Test plan
- Reset, then draw_area=1 at any x/y: RGB=000000 three cycles later; *_o equal the inputs delayed 3; blink_phase=0.
- Write rect0 {en=1, blink=0, on=3, x0=508, x1=526, y0=316, y1=385} mid-frame: no change before the v_sync rise. After it:
  - (508,316) gives A8B043;
  - (526,385) gives A8B043;
  - (507,316) and (527,385) give 000000.
- Add rect1 {en=1, on=5, x 500..520, y 300..400}: (510,350) gives A8B043 (rect0 wins); (502,350) gives FFA900.
- Rect0 blink=1, off=4, default BLINK_DIV_W: after 16 v_sync rises (510,350) gives 2B3314; after 32 it gives A8B043 again.
- pal_we addr 3 = 123456 while rect0 is displayed: pixels read from the next cycle show 123456. draw_area=0 over the rectangle gives 000000.
- cfg_we disabling rect0 in the exact v_sync rise cycle: rect0 still drawn that frame, gone after the next rise. Reset asserted mid-frame: RGB 0 next cycle; rect0 absent after release until rewritten and committed.
